fetch_unit: RTL and testbench

- Instruction-fetch front end. It consumes the next-PC produced by the branch/PC unit and issues word fetches to instruction memory.
- It buffers returned instructions with their PCs and hands them to decode over a valid/ready handshake.
- A taken branch arrives as a redirect. The redirect flushes buffered and in-flight fetches and restarts fetch at the new PC.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with credit-limited buffer and redirect flush
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        fault
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic          fault_q, fault_d;

  logic [31:0]   buf_pc   [DEPTH];
  logic [31:0]   buf_data [DEPTH];

  logic          req_fire;
  logic          push;
  logic          pop;
  logic [CW:0]   credits_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Buffered entries and in-flight requests share one credit pool, so a response always has room.
  assign credits_used = {1'b0, out_q} + {1'b0, cnt_q};
  assign req_valid    = !reset && !fault_q && !redirect_valid && (credits_used < DEPTH_C);
  assign req_addr     = fetch_pc_q;
  assign instr_valid  = !reset && (cnt_q != '0) && !redirect_valid;
  assign instr_pc     = buf_pc[rd_q];
  assign instr_data   = buf_data[rd_q];
  assign fault        = fault_q;

  assign req_fire = req_valid && req_ready;
  assign pop      = instr_valid && instr_ready;
  assign push     = resp_valid && !redirect_valid && (drop_q == '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    fault_d    = fault_q;
    out_d      = out_q + CW'(req_fire) - CW'(resp_valid);
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (redirect_valid) begin
      // Every request still in flight after this cycle belongs to the old path.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_d     = out_d;
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
      fault_d    = (redirect_pc[1:0] != 2'b00);
    end else begin
      if (resp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end
      if (push) begin
        wr_d = ptr_inc(wr_q);
      end
      if (pop) begin
        rd_d = ptr_inc(rd_q);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      fault_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      fault_q    <= fault_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      buf_pc[wr_q]   <= resp_pc_q;
      buf_data[wr_q] <= resp_data;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && (cnt_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with an in-order memory model
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        fault;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        mem_hold = 1'b0;
  logic [31:0] mem_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] got_pc_q[$];
  logic [31:0] got_data_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .fault          (fault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: record handshakes before the edge, then let memory answer at the next negedge.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = req_valid && req_ready && !reset;
    a   = req_addr;
    if (acc) begin
      acc_q.push_back(a);
      mem_q.push_back(a);
    end
    if (instr_valid && instr_ready) begin
      got_pc_q.push_back(instr_pc);
      got_data_q.push_back(instr_data);
    end
    @(posedge clock);
    @(negedge clock);
    if (!reset && !mem_hold && mem_q.size() > 0) begin
      resp_valid = 1'b1;
      resp_data  = mem_word(mem_q.pop_front());
    end else begin
      resp_valid = 1'b0;
      resp_data  = 32'd0;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    resp_valid     = 1'b0;
    mem_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clock);
    settle();
    check("rst_req_valid",   32'(req_valid),   32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_fault",       32'(fault),       32'd0);
    check("rst_req_addr",    req_addr,         32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Streaming with 1-cycle memory and decode always ready
    req_ready = 1'b1; instr_ready = 1'b1;
    acc_q.delete(); got_pc_q.delete(); got_data_q.delete();
    settle();
    check("t1_c0_req_valid",   32'(req_valid),   32'd1);
    check("t1_c0_req_addr",    req_addr,         32'd0);
    check("t1_c0_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    settle();
    check("t1_c1_req_valid",   32'(req_valid),   32'd1);
    check("t1_c1_req_addr",    req_addr,         32'd4);
    check("t1_c1_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    settle();
    check("t1_c2_instr_valid", 32'(instr_valid), 32'd1);
    check("t1_c2_instr_pc",    instr_pc,         32'd0);
    check("t1_c2_instr_data",  instr_data,       32'hC0DE_0000);
    check("t1_c2_req_valid",   32'(req_valid),   32'd0);
    tick();
    repeat (4) tick();
    begin
      logic [31:0] exp_acc [5];
      logic [31:0] exp_pc  [4];
      logic [31:0] exp_dat [4];
      exp_acc = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16};
      exp_pc  = '{32'd0, 32'd4, 32'd8, 32'd12};
      exp_dat = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008, 32'hC0DE_000C};
      check("t1_acc_count", 32'(acc_q.size()),    32'd5);
      check("t1_got_count", 32'(got_pc_q.size()), 32'd4);
      for (int i = 0; i < 5; i++)
        check($sformatf("t1_acc%0d", i), (i < acc_q.size()) ? acc_q[i] : 32'hFFFF_FFFF, exp_acc[i]);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t1_pc%0d", i),   (i < got_pc_q.size()) ? got_pc_q[i] : 32'hFFFF_FFFF, exp_pc[i]);
        check($sformatf("t1_data%0d", i), (i < got_data_q.size()) ? got_data_q[i] : 32'hFFFF_FFFF, exp_dat[i]);
      end
    end

    // Decode stalled: credits run out after two requests
    do_reset();
    req_ready = 1'b1; instr_ready = 1'b0;
    acc_q.delete();
    repeat (5) tick();
    settle();
    check("t2_acc_count",   32'(acc_q.size()),                              32'd2);
    check("t2_acc0",        (acc_q.size() > 0) ? acc_q[0] : 32'hFFFF_FFFF,  32'd0);
    check("t2_acc1",        (acc_q.size() > 1) ? acc_q[1] : 32'hFFFF_FFFF,  32'd4);
    check("t2_req_valid",   32'(req_valid),                                 32'd0);
    check("t2_head_valid",  32'(instr_valid),                               32'd1);
    check("t2_head_pc",     instr_pc,                                       32'd0);
    instr_ready = 1'b1;
    settle();
    check("t2_pop0_pc",     instr_pc,          32'd0);
    check("t2_pop0_req",    32'(req_valid),    32'd0);
    tick();
    mem_hold = 1'b1;
    settle();
    check("t2_pop1_pc",     instr_pc,          32'd4);
    check("t2_resume_req",  32'(req_valid),    32'd1);
    check("t2_resume_addr", req_addr,          32'd8);
    tick();

    // Two stale requests in flight when the redirect lands
    settle();
    check("t3_req12_valid", 32'(req_valid),    32'd1);
    check("t3_req12_addr",  req_addr,          32'd12);
    tick();
    settle();
    check("t3_full_credit", 32'(req_valid),    32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h100; mem_hold = 1'b0;
    settle();
    check("t3_redir_req",   32'(req_valid),    32'd0);
    check("t3_redir_instr", 32'(instr_valid),  32'd0);
    tick();
    redirect_valid = 1'b0;
    settle();
    check("t3_drain_req",   32'(req_valid),    32'd0);
    check("t3_drain_instr", 32'(instr_valid),  32'd0);
    tick();
    settle();
    check("t3_new_req",     32'(req_valid),    32'd1);
    check("t3_new_addr",    req_addr,          32'h100);
    check("t3_drop2_instr", 32'(instr_valid),  32'd0);
    tick();
    settle();
    check("t3_lat_instr",   32'(instr_valid),  32'd0);
    tick();
    settle();
    check("t3_first_valid", 32'(instr_valid),  32'd1);
    check("t3_first_pc",    instr_pc,          32'h100);
    check("t3_first_data",  instr_data,        32'hC0DE_0100);
    tick();

    // Redirect coinciding with a response and a buffered entry
    instr_ready = 1'b0;
    settle();
    check("t4_buf_valid",   32'(instr_valid),  32'd1);
    check("t4_buf_pc",      instr_pc,          32'h104);
    check("t4_req_addr",    req_addr,          32'h108);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h180;
    settle();
    check("t4_redir_instr", 32'(instr_valid),  32'd0);
    check("t4_redir_req",   32'(req_valid),    32'd0);
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b1;
    settle();
    check("t4_flushed",     32'(instr_valid),  32'd0);
    check("t4_new_addr",    req_addr,          32'h180);
    check("t4_new_req",     32'(req_valid),    32'd1);
    tick();
    settle();
    check("t4_lat_instr",   32'(instr_valid),  32'd0);
    tick();
    settle();
    check("t4_first_valid", 32'(instr_valid),  32'd1);
    check("t4_first_pc",    instr_pc,          32'h180);
    tick();

    // Misaligned redirect halts fetch until an aligned one arrives
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    settle();
    check("t5_redir_req",   32'(req_valid),    32'd0);
    tick();
    redirect_valid = 1'b0;
    settle();
    check("t5_fault",       32'(fault),        32'd1);
    check("t5_fault_req",   32'(req_valid),    32'd0);
    check("t5_fault_instr", 32'(instr_valid),  32'd0);
    tick();
    tick();
    settle();
    check("t5_fault_hold",  32'(fault),        32'd1);
    check("t5_hold_req",    32'(req_valid),    32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h106;
    tick();
    redirect_valid = 1'b0;
    settle();
    check("t5_refault",     32'(fault),        32'd1);
    check("t5_refault_req", 32'(req_valid),    32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    settle();
    check("t5_clear_cycle", 32'(fault),        32'd1);
    tick();
    redirect_valid = 1'b0;
    settle();
    check("t5_cleared",     32'(fault),        32'd0);
    check("t5_resume_req",  32'(req_valid),    32'd1);
    check("t5_resume_addr", req_addr,          32'h200);

    // Reset mid-stream with a full buffer
    instr_ready = 1'b0;
    repeat (4) tick();
    settle();
    check("t6_full_valid",  32'(instr_valid),  32'd1);
    check("t6_full_pc",     instr_pc,          32'h200);
    check("t6_full_data",   instr_data,        32'hC0DE_0200);
    check("t6_full_req",    32'(req_valid),    32'd0);
    reset = 1'b1; resp_valid = 1'b0; mem_q.delete();
    settle();
    check("t6_rst_req",     32'(req_valid),    32'd0);
    check("t6_rst_instr",   32'(instr_valid),  32'd0);
    check("t6_rst_fault",   32'(fault),        32'd0);
    check("t6_rst_addr",    req_addr,          32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0; instr_ready = 1'b1;
    settle();
    check("t6_restart_req", 32'(req_valid),    32'd1);
    check("t6_restart_addr", req_addr,         32'd0);
    tick();
    tick();
    settle();
    check("t6_first_valid", 32'(instr_valid),  32'd1);
    check("t6_first_pc",    instr_pc,          32'd0);
    check("t6_first_data",  instr_data,        32'hC0DE_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
